registered: RTL and testbench

Registered-output FIFO for the AXI switch reference example. Built around addressable shift-register (SRL) storage: writes shift in at position 0; reads take the oldest entry at address `occupancy-1`. The oldest entry is held in an output register so that `m_payload` is always a flop output. Sits on switch datapaths as a valid/ready decoupling buffer of depth `2**C_AWIDTH + 1`.

---
 rtl/registered.sv | 161 ++++++++++++++++
 tb/tb_registered.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/registered.sv
// registered: valid/ready decoupling FIFO with a registered output.
//
// Storage is split in two parts:
//   - an addressable shift register (SRL) of depth 2**C_AWIDTH. Writes shift
//     in at position 0, and the oldest SRL entry is always at srl_count-1.
//   - an output register that holds the oldest entry of the whole FIFO, so
//     m_payload always comes straight from a flop.
// Total capacity is 2**C_AWIDTH + 1 words.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. m_valid/m_payload do not change while
// m_valid=1 and m_ready=0. s_valid is ignored while s_ready=0.
//
// Ports:
//   clk        in   clock, rising edge
//   aresetn    in   asynchronous active-low reset (SRL contents not cleared)
//   s_valid    in   write data valid
//   s_ready    out  FIFO can accept a write
//   s_payload  in   write data, C_WIDTH bits
//   m_valid    out  m_payload holds the oldest entry
//   m_ready    in   downstream accepts the entry
//   m_payload  out  oldest entry, C_WIDTH bits (output register)
//   count      out  total occupancy, C_AWIDTH+1 bits
//   fsm_state  out  control state (0=ZERO, 1=ONE, 2=MORE) for observation
module registered #(
  parameter int C_WIDTH  = 8,
  parameter int C_AWIDTH = 5
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [C_WIDTH-1:0]  s_payload,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [C_WIDTH-1:0]  m_payload,
  output logic [C_AWIDTH:0]   count,
  output logic [1:0]          fsm_state
);

  localparam int P_SRLDEPTH = 2 ** C_AWIDTH;
  localparam logic [C_AWIDTH:0] SRL_FULL = (C_AWIDTH + 1)'(P_SRLDEPTH);
  localparam logic [C_AWIDTH:0] SRL_ONE  = (C_AWIDTH + 1)'(1);

  // ZERO: nothing held. ONE: only the output register holds data.
  // MORE: output register valid and the SRL holds at least one entry.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    MORE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [C_AWIDTH:0]    srl_count;
  logic [C_AWIDTH:0]    srl_count_next;
  logic                 rst_done;
  logic [C_WIDTH-1:0]   out_reg;
  logic [C_WIDTH-1:0]   out_reg_next;
  logic                 out_load;
  logic                 shift_en;
  logic [C_AWIDTH-1:0]  srl_addr;
  logic [C_WIDTH-1:0]   srl_rdata;
  logic                 push;
  logic                 pop;

  logic [C_WIDTH-1:0]   srl [P_SRLDEPTH];

  assign m_valid   = (state != ZERO);
  assign s_ready   = rst_done & (srl_count != SRL_FULL);
  assign m_payload = out_reg;
  assign count     = srl_count + {{C_AWIDTH{1'b0}}, m_valid};
  assign fsm_state = state;

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  // The read address only matters when srl_count >= 1; at srl_count = 32 the
  // low bits are 0 and the subtraction wraps to 31, which is the right slot.
  assign srl_addr  = srl_count[C_AWIDTH-1:0] - C_AWIDTH'(1);
  // Combinational read sees pre-shift contents, so a shift in the same cycle
  // as a read is safe.
  assign srl_rdata = srl[srl_addr];

  // SRL storage: no reset, srl_count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      srl[0] <= s_payload;
      for (int i = 1; i < P_SRLDEPTH; i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  // rst_done keeps s_ready low for the first edge after reset release.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ZERO;
      srl_count <= '0;
      rst_done  <= 1'b0;
      out_reg   <= '0;
    end else begin
      state     <= state_next;
      srl_count <= srl_count_next;
      rst_done  <= 1'b1;
      if (out_load) begin
        out_reg <= out_reg_next;
      end
    end
  end

  always_comb begin
    state_next     = state;
    srl_count_next = srl_count;
    out_load       = 1'b0;
    out_reg_next   = s_payload;
    shift_en       = 1'b0;
    unique case (state)
      ZERO: begin
        if (push) begin
          out_load   = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Incoming word goes straight to the output register.
          out_load = 1'b1;
        end else if (push) begin
          shift_en       = 1'b1;
          srl_count_next = SRL_ONE;
          state_next     = MORE;
        end else if (pop) begin
          state_next = ZERO;
        end
      end
      MORE: begin
        if (pop) begin
          out_load     = 1'b1;
          out_reg_next = srl_rdata;
        end
        if (push) begin
          shift_en = 1'b1;
        end
        if (pop && !push) begin
          srl_count_next = srl_count - SRL_ONE;
          if (srl_count == SRL_ONE) begin
            state_next = ONE;
          end
        end else if (push && !pop) begin
          srl_count_next = srl_count + SRL_ONE;
        end
      end
      default: begin
        state_next     = ZERO;
        srl_count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_registered.sv
// tb_registered: randomized and directed checks of the registered FIFO
// against a queue-based reference model of a 33-entry FIFO.
module tb_registered;

  localparam int W   = 8;
  localparam int AW  = 5;
  localparam int CAP = 2 ** AW + 1;

  logic          clk;
  logic          aresetn;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_payload;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_payload;
  logic [AW:0]   count;
  logic [1:0]    fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: contents of the FIFO, oldest first.
  logic [W-1:0] exp_q[$];
  bit           model_rst_done;
  bit           prev_stall;
  logic [W-1:0] stall_exp;

  registered #(.C_WIDTH(W), .C_AWIDTH(AW)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_payload (s_payload),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_payload (m_payload),
    .count     (count),
    .fsm_state (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return model_rst_done && (exp_q.size() < CAP);
  endfunction

  // One clock cycle, entered and left at a negedge. Outputs are checked
  // against the model before the rising edge, then the model advances.
  task automatic cycle(input logic sv, input logic [W-1:0] sp, input logic mr);
    bit do_push;
    bit do_pop;
    s_valid   = sv;
    s_payload = sp;
    m_ready   = mr;
    #1;
    check_eq("s_ready", 32'(s_ready), 32'(model_ready()));
    check_eq("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
    check_eq("count", 32'(count), 32'(exp_q.size()));
    check_eq("state", 32'(fsm_state),
             (exp_q.size() == 0) ? 32'd0 : (exp_q.size() == 1) ? 32'd1 : 32'd2);
    if (exp_q.size() > 0) begin
      check_eq("m_payload", 32'(m_payload), 32'(exp_q[0]));
    end
    if (prev_stall) begin
      check_eq("stall_hold", 32'(m_payload), 32'(stall_exp));
    end
    do_push    = sv && model_ready() && aresetn;
    do_pop     = mr && (exp_q.size() > 0) && aresetn;
    prev_stall = (exp_q.size() > 0) && !mr && aresetn;
    if (exp_q.size() > 0) stall_exp = exp_q[0];
    @(posedge clk);
    if (aresetn) begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(sp);
      model_rst_done = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    int accepted;
    aresetn        = 1'b0;
    s_valid        = 1'b0;
    s_payload      = '0;
    m_ready        = 1'b0;
    model_rst_done = 1'b0;
    prev_stall     = 1'b0;
    stall_exp      = '0;

    // Reset check with random inputs
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      s_valid   = 1'($urandom_range(0, 1));
      s_payload = W'($urandom);
      m_ready   = 1'($urandom_range(0, 1));
      #1;
      check_eq("rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_m_payload", 32'(m_payload), 32'd0);
      @(negedge clk);
    end
    aresetn = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    #1 check_eq("ready_after_release", 32'(s_ready), 32'd1);

    // Single word
    cycle(1'b1, 8'hA5, 1'b1);
    check_eq("single_valid", 32'(m_valid), 32'd1);
    check_eq("single_payload", 32'(m_payload), 32'hA5);
    check_eq("single_count1", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("single_count0", 32'(count), 32'd0);

    // Fill 0..40 with no reads
    accepted = 0;
    for (int i = 0; i <= 40; i++) begin
      if (s_ready) accepted++;
      cycle(1'b1, W'(i), 1'b0);
    end
    check_eq("fill_accepted", 32'(accepted), 32'd33);
    check_eq("fill_count", 32'(count), 32'd33);
    check_eq("fill_s_ready", 32'(s_ready), 32'd0);
    // Drain in order
    for (int i = 0; i < CAP; i++) begin
      check_eq("drain_order", 32'(m_payload), 32'(i));
      cycle(1'b0, 8'h00, 1'b1);
    end
    check_eq("drain_count", 32'(count), 32'd0);
    check_eq("drain_m_valid", 32'(m_valid), 32'd0);

    // Streaming
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, W'(8'h40 + i), 1'b1);
      check_eq("stream_count", 32'(count), 32'd1);
      check_eq("stream_data", 32'(m_payload), 32'(W'(8'h40 + i)));
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1);

    // Random backpressure
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() > 0) cycle(1'b0, 8'h00, 1'b1);

    // Mid-operation reset
    for (int i = 0; i < 20; i++) cycle(1'b1, W'($urandom), 1'b0);
    check_eq("pre_reset_count", 32'(count), 32'd20);
    aresetn = 1'b0;
    #1;
    check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
    check_eq("midrst_count", 32'(count), 32'd0);
    check_eq("midrst_s_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    model_rst_done = 1'b0;
    prev_stall     = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    check_eq("post_rst_valid", 32'(m_valid), 32'd1);
    check_eq("post_rst_payload", 32'(m_payload), 32'h3C);
    check_eq("post_rst_count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("post_rst_empty", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
